// File: rtl/univ_reg_pkg.sv
// Shared types for the universal register: the operation mode encoding.
package univ_reg_pkg;

    typedef enum logic [2:0] {
        HOLD = 3'b000,
        LOAD = 3'b001,
        SHL  = 3'b010,
        SHR  = 3'b011,
        ROL  = 3'b100,
        ROR  = 3'b101,
        INC  = 3'b110,
        DEC  = 3'b111
    } mode_e;

endpackage

// File: rtl/univ_reg_next.sv
// Next-state datapath of the universal register. It is purely combinational:
// given the current contents and carry, it produces the value and carry that
// the selected mode would register. Priority/enable is handled by the caller.
module univ_reg_next
    import univ_reg_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] i_cur,
    input  mode_e        i_mode,
    input  logic [N-1:0] i_in,
    input  logic         i_ser_in,
    input  logic         i_carry,
    output logic [N-1:0] o_nxt,
    output logic         o_nxt_carry
);

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    // Mode decode: every encoding is legal, HOLD keeps both value and carry.
    always_comb begin
        o_nxt       = i_cur;
        o_nxt_carry = i_carry;
        case (i_mode)
            HOLD: begin
                o_nxt       = i_cur;
                o_nxt_carry = i_carry;
            end
            LOAD: begin
                o_nxt       = i_in;
                o_nxt_carry = 1'b0;
            end
            SHL: begin
                o_nxt       = {i_cur[N-2:0], i_ser_in};
                o_nxt_carry = i_cur[N-1];
            end
            SHR: begin
                o_nxt       = {i_ser_in, i_cur[N-1:1]};
                o_nxt_carry = i_cur[0];
            end
            ROL: begin
                o_nxt       = {i_cur[N-2:0], i_cur[N-1]};
                o_nxt_carry = i_cur[N-1];
            end
            ROR: begin
                o_nxt       = {i_cur[0], i_cur[N-1:1]};
                o_nxt_carry = i_cur[0];
            end
            INC: begin
                o_nxt       = i_cur + ONE;
                o_nxt_carry = (i_cur == {N{1'b1}});
            end
            DEC: begin
                o_nxt       = i_cur - ONE;
                o_nxt_carry = (i_cur == {N{1'b0}});
            end
            default: begin
                o_nxt       = i_cur;
                o_nxt_carry = i_carry;
            end
        endcase
    end

endmodule

// File: rtl/univ_register.sv
// N-bit universal register: hold, load, shift, rotate, increment, decrement.
// Holds only the state flops and the clear/sync-clear/enable priority; the
// per-mode arithmetic lives in univ_reg_next. The zero flag is registered
// from the value being written, so it is valid on the same cycle as out.
module univ_register
    import univ_reg_pkg::*;
#(
    parameter int           N       = 8,
    parameter logic [N-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         clear_n,
    input  logic         sync_clr,
    input  logic         en,
    input  logic [2:0]   mode,
    input  logic [N-1:0] in,
    input  logic         ser_in,
    output logic [N-1:0] out,
    output logic         carry,
    output logic         zero
);

    localparam logic RST_ZERO = (RST_VAL == {N{1'b0}});

    logic [N-1:0] r_out;
    logic         r_carry;
    logic         r_zero;
    logic [N-1:0] w_nxt;
    logic         w_nxt_carry;

    univ_reg_next #(.N(N)) u_next (
        .i_cur       (r_out),
        .i_mode      (mode_e'(mode)),
        .i_in        (in),
        .i_ser_in    (ser_in),
        .i_carry     (r_carry),
        .o_nxt       (w_nxt),
        .o_nxt_carry (w_nxt_carry)
    );

    // State update: async reset > sync clear > enable gate > mode result.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_out   <= RST_VAL;
            r_carry <= 1'b0;
            r_zero  <= RST_ZERO;
        end else if (sync_clr) begin
            r_out   <= RST_VAL;
            r_carry <= 1'b0;
            r_zero  <= RST_ZERO;
        end else if (en) begin
            r_out   <= w_nxt;
            r_carry <= w_nxt_carry;
            r_zero  <= (w_nxt == {N{1'b0}});
        end
    end

    assign out   = r_out;
    assign carry = r_carry;
    assign zero  = r_zero;

endmodule

// File: tb/tb_univ_register.sv
// Bench for univ_register: an 8-bit instance driven from a vector table and a
// 4-bit instance (RST_VAL = 5) driven by hand-written sequences. Expected
// {out, carry, zero} are pushed when stimulus is applied and popped after the
// clock edge that should produce them.
module tb_univ_register;
    import univ_reg_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic clear_n = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic       sync_clr8 = 1'b0, en8 = 1'b0, ser8 = 1'b0;
    logic [2:0] mode8 = 3'b000;
    logic [7:0] in8 = 8'h00;
    logic [7:0] out8;
    logic       carry8, zero8;

    logic       sync_clr4 = 1'b0, en4 = 1'b0, ser4 = 1'b0;
    logic [2:0] mode4 = 3'b000;
    logic [3:0] in4 = 4'h0;
    logic [3:0] out4;
    logic       carry4, zero4;

    univ_register #(.N(8)) dut8 (
        .clk(clk), .clear_n(clear_n), .sync_clr(sync_clr8), .en(en8),
        .mode(mode8), .in(in8), .ser_in(ser8),
        .out(out8), .carry(carry8), .zero(zero8)
    );

    univ_register #(.N(4), .RST_VAL(4'h5)) dut4 (
        .clk(clk), .clear_n(clear_n), .sync_clr(sync_clr4), .en(en4),
        .mode(mode4), .in(in4), .ser_in(ser4),
        .out(out4), .carry(carry4), .zero(zero4)
    );

    // ---------------- scoreboard ----------------
    logic [9:0] exp8_q[$];   // {out, carry, zero}
    logic [5:0] exp4_q[$];
    int checks = 0;
    int errors = 0;
    string cur_name = "";

    task automatic pop_check();
        logic [9:0] e8;
        logic [5:0] e4;
        while (exp8_q.size() > 0) begin
            e8 = exp8_q.pop_front();
            checks++;
            if ({out8, carry8, zero8} !== e8) begin
                errors++;
                $display("FAIL %s (N=8): got out=%h carry=%b zero=%b, expected out=%h carry=%b zero=%b",
                         cur_name, out8, carry8, zero8, e8[9:2], e8[1], e8[0]);
            end
        end
        while (exp4_q.size() > 0) begin
            e4 = exp4_q.pop_front();
            checks++;
            if ({out4, carry4, zero4} !== e4) begin
                errors++;
                $display("FAIL %s (N=4): got out=%h carry=%b zero=%b, expected out=%h carry=%b zero=%b",
                         cur_name, out4, carry4, zero4, e4[5:2], e4[1], e4[0]);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        pop_check();
    endtask

    // ---------------- drivers ----------------
    task automatic set8(input logic sc, input logic e, input logic [2:0] m,
                        input logic [7:0] d, input logic s,
                        input logic [7:0] eo, input logic ec, input logic ez);
        sync_clr8 = sc; en8 = e; mode8 = m; in8 = d; ser8 = s;
        exp8_q.push_back({eo, ec, ez});
    endtask

    task automatic set4(input logic sc, input logic e, input logic [2:0] m,
                        input logic [3:0] d, input logic s,
                        input logic [3:0] eo, input logic ec, input logic ez);
        sync_clr4 = sc; en4 = e; mode4 = m; in4 = d; ser4 = s;
        exp4_q.push_back({eo, ec, ez});
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       sc;
        logic       en;
        logic [2:0] mode;
        logic [7:0] din;
        logic       ser;
        logic [7:0] eo;
        logic       ec;
        logic       ez;
        string      name;
    } vec_t;

    localparam int NV = 30;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic sc, input logic e, input logic [2:0] m,
                                input logic [7:0] d, input logic s,
                                input logic [7:0] eo, input logic ec, input logic ez,
                                input string nm);
        vec_t v;
        v.sc = sc; v.en = e; v.mode = m; v.din = d; v.ser = s;
        v.eo = eo; v.ec = ec; v.ez = ez; v.name = nm;
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mk(0, 1, LOAD, 8'hA5, 0, 8'hA5, 0, 0, "load_a5");
        vecs[1]  = mk(0, 1, LOAD, 8'h81, 0, 8'h81, 0, 0, "load_81");
        vecs[2]  = mk(0, 1, SHL,  8'h00, 0, 8'h02, 1, 0, "shl_81");
        vecs[3]  = mk(0, 1, LOAD, 8'h81, 0, 8'h81, 0, 0, "load_clears_carry");
        vecs[4]  = mk(0, 1, SHR,  8'h00, 1, 8'hC0, 1, 0, "shr_81_ser1");
        vecs[5]  = mk(0, 1, LOAD, 8'h81, 0, 8'h81, 0, 0, "load_81b");
        vecs[6]  = mk(0, 1, ROL,  8'h00, 1, 8'h03, 1, 0, "rol_81");
        vecs[7]  = mk(0, 1, LOAD, 8'h81, 0, 8'h81, 0, 0, "load_81c");
        vecs[8]  = mk(0, 1, ROR,  8'h00, 0, 8'hC0, 1, 0, "ror_81");
        vecs[9]  = mk(0, 1, HOLD, 8'h12, 1, 8'hC0, 1, 0, "hold_mode");
        vecs[10] = mk(0, 1, LOAD, 8'hFE, 0, 8'hFE, 0, 0, "load_fe");
        vecs[11] = mk(0, 1, INC,  8'h00, 0, 8'hFF, 0, 0, "inc_fe");
        vecs[12] = mk(0, 1, INC,  8'h00, 0, 8'h00, 1, 1, "inc_wrap");
        vecs[13] = mk(0, 1, LOAD, 8'h00, 0, 8'h00, 0, 1, "load_00");
        vecs[14] = mk(0, 1, DEC,  8'h00, 0, 8'hFF, 1, 0, "dec_wrap");
        vecs[15] = mk(0, 1, DEC,  8'h00, 0, 8'hFE, 0, 0, "dec_ff");
        vecs[16] = mk(0, 1, LOAD, 8'h01, 0, 8'h01, 0, 0, "load_01");
        vecs[17] = mk(0, 1, DEC,  8'h00, 0, 8'h00, 0, 1, "dec_to_zero");
        vecs[18] = mk(0, 1, LOAD, 8'h79, 0, 8'h79, 0, 0, "load_79");
        vecs[19] = mk(0, 1, SHR,  8'h00, 0, 8'h3C, 1, 0, "shr_79");
        vecs[20] = mk(0, 0, INC,  8'hFF, 1, 8'h3C, 1, 0, "en0_inc_hold");
        vecs[21] = mk(0, 0, LOAD, 8'h77, 0, 8'h3C, 1, 0, "en0_load_hold");
        vecs[22] = mk(1, 1, LOAD, 8'h77, 0, 8'h00, 0, 1, "sclr_over_load");
        vecs[23] = mk(0, 1, LOAD, 8'h55, 0, 8'h55, 0, 0, "load_55");
        vecs[24] = mk(1, 0, INC,  8'h00, 0, 8'h00, 0, 1, "sclr_en0");
        vecs[25] = mk(0, 1, LOAD, 8'h7F, 0, 8'h7F, 0, 0, "load_7f");
        vecs[26] = mk(0, 1, INC,  8'h00, 0, 8'h80, 0, 0, "inc_7f");
        vecs[27] = mk(0, 1, SHL,  8'h00, 1, 8'h01, 1, 0, "shl_80_ser1");
        vecs[28] = mk(0, 1, SHR,  8'h00, 0, 8'h00, 1, 1, "shr_01_to_zero");
        vecs[29] = mk(0, 1, ROL,  8'h00, 0, 8'h00, 0, 1, "rol_zero");

        // Async reset mid-cycle, before any clock edge.
        #1 clear_n = 1'b0;
        #1;
        cur_name = "async_reset";
        exp8_q.push_back({8'h00, 1'b0, 1'b1});
        exp4_q.push_back({4'h5, 1'b0, 1'b0});
        pop_check();

        // Reset holds through a clock edge even with an active load.
        set8(0, 1, LOAD, 8'hFF, 0, 8'h00, 0, 1);
        set4(0, 1, LOAD, 4'hF, 0, 4'h5, 0, 0);
        cur_name = "reset_hold";
        tick();

        @(negedge clk);
        en8 = 1'b0; en4 = 1'b0;
        clear_n = 1'b1;

        // Table-driven run on the 8-bit instance; dut4 idles with en=0.
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            set8(vecs[i].sc, vecs[i].en, vecs[i].mode, vecs[i].din, vecs[i].ser,
                 vecs[i].eo, vecs[i].ec, vecs[i].ez);
            cur_name = vecs[i].name;
            tick();
        end

        // 4-bit instance with non-zero reset value.
        @(negedge clk); en8 = 1'b0; set4(0, 1, LOAD, 4'hF, 0, 4'hF, 0, 0); cur_name = "n4_load_f";  tick();
        @(negedge clk); set4(0, 1, INC,  4'h0, 0, 4'h0, 1, 1);            cur_name = "n4_inc_wrap"; tick();
        @(negedge clk); set4(0, 1, LOAD, 4'h8, 0, 4'h8, 0, 0);            cur_name = "n4_load_8";   tick();
        @(negedge clk); set4(0, 1, SHL,  4'h0, 0, 4'h0, 1, 1);            cur_name = "n4_shl_8";    tick();
        @(negedge clk); set4(0, 1, DEC,  4'h0, 0, 4'hF, 1, 0);            cur_name = "n4_dec_wrap"; tick();
        @(negedge clk); set4(1, 1, INC,  4'h0, 0, 4'h5, 0, 0);            cur_name = "n4_sclr";     tick();
        @(negedge clk); set4(0, 1, INC,  4'h0, 0, 4'h6, 0, 0);            cur_name = "n4_inc_5";    tick();

        // Mid-sequence async reset aborts counting; counting restarts from RST_VAL.
        @(negedge clk);
        set8(0, 1, INC, 8'h00, 0, 8'h01, 0, 0);
        set4(0, 1, INC, 4'h0, 0, 4'h7, 0, 0);
        cur_name = "pre_abort_inc";
        tick();
        @(negedge clk);
        #2 clear_n = 1'b0;
        #1;
        exp8_q.push_back({8'h00, 1'b0, 1'b1});
        exp4_q.push_back({4'h5, 1'b0, 1'b0});
        cur_name = "mid_async_reset";
        pop_check();
        @(negedge clk);
        clear_n = 1'b1;
        set8(0, 1, INC, 8'h00, 0, 8'h01, 0, 0);
        set4(0, 1, INC, 4'h0, 0, 4'h6, 0, 0);
        cur_name = "post_reset_inc";
        tick();

        @(negedge clk);
        en8 = 1'b0; en4 = 1'b0;
        if (exp8_q.size() != 0 || exp4_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d/%0d entries left, expected 0/0",
                     exp8_q.size(), exp4_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
